// File: rtl/native2axil_adapter.sv
// native2axil_adapter: AXI4-Lite master end of the native/AXI-Lite adapter pair.
// Each native request becomes exactly one AXI-Lite transaction, with one outstanding at a time.
// A nonzero native_wstrb selects a write (AW+W, then B). A zero strobe selects a read (AR, then R).
// Completion is signalled by a one-cycle native_ready pulse carrying native_rdata and native_err.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   native_valid/ready    request valid (held until ready) / one-cycle completion pulse
//   native_addr/wdata/wstrb  request fields, sampled only when idle
//   native_rdata/err      read data (held until the next read) and not-OKAY response flag
//   m_axil_*              AXI4-Lite master channels AW, W, B, AR, R (prot tied to 3'b000)
//
// Every output is driven from a flop, so no input reaches an output combinationally.
module native2axil_adapter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // native requester side
  input  logic                  native_valid,
  output logic                  native_ready,
  input  logic [ADDR_WIDTH-1:0] native_addr,
  input  logic [DATA_WIDTH-1:0] native_wdata,
  input  logic [STRB_WIDTH-1:0] native_wstrb,
  output logic [DATA_WIDTH-1:0] native_rdata,
  output logic                  native_err,
  // AXI4-Lite write address
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  // AXI4-Lite write data
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  // AXI4-Lite write response
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  // AXI4-Lite read address
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  // AXI4-Lite read data
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdData,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // A channel counts as done once its valid has already dropped or is handshaking now.
  logic aw_done, w_done;
  assign aw_done = !awvalid_q || m_axil_awready;
  assign w_done  = !wvalid_q || m_axil_wready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    ready_d   = 1'b0;
    err_d     = err_q;
    rdata_d   = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (native_valid) begin
          addr_d  = native_addr;
          wdata_d = native_wdata;
          wstrb_d = native_wstrb;
          if (native_wstrb != '0) begin
            state_d   = StWrReq;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = StRdReq;
            arvalid_d = 1'b1;
          end
        end
      end
      StWrReq: begin
        if (awvalid_q && m_axil_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axil_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          state_d  = StWrResp;
          bready_d = 1'b1;
        end
      end
      StWrResp: begin
        if (m_axil_bvalid) begin
          state_d  = StDone;
          bready_d = 1'b0;
          err_d    = (m_axil_bresp != 2'b00);
          ready_d  = 1'b1;
        end
      end
      StRdReq: begin
        if (m_axil_arready) begin
          state_d   = StRdData;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      StRdData: begin
        if (m_axil_rvalid) begin
          state_d  = StDone;
          rready_d = 1'b0;
          rdata_d  = m_axil_rdata;
          err_d    = (m_axil_rresp != 2'b00);
          ready_d  = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign native_ready   = ready_q;
  assign native_rdata   = rdata_q;
  assign native_err     = err_q;
  assign m_axil_awaddr  = addr_q;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_native2axil_adapter.sv
// Directed bench for native2axil_adapter: a configurable AXI-Lite subordinate with per-channel
// ready/response delays, a native requester task, and handshake monitors. The subordinate and
// the requester act on the falling edge, so DUT outputs are stable when they are read.
module tb_native2axil_adapter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        native_valid, native_ready;
  logic [31:0] native_addr, native_wdata, native_rdata;
  logic [3:0]  native_wstrb;
  logic        native_err;
  logic [31:0] m_axil_awaddr, m_axil_wdata, m_axil_araddr, m_axil_rdata;
  logic [2:0]  m_axil_awprot, m_axil_arprot;
  logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic [3:0]  m_axil_wstrb;
  logic [1:0]  m_axil_bresp, m_axil_rresp;
  logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
  logic        m_axil_rvalid, m_axil_rready;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  native2axil_adapter #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .native_valid   (native_valid),
    .native_ready   (native_ready),
    .native_addr    (native_addr),
    .native_wdata   (native_wdata),
    .native_wstrb   (native_wstrb),
    .native_rdata   (native_rdata),
    .native_err     (native_err),
    .m_axil_awaddr  (m_axil_awaddr),
    .m_axil_awprot  (m_axil_awprot),
    .m_axil_awvalid (m_axil_awvalid),
    .m_axil_awready (m_axil_awready),
    .m_axil_wdata   (m_axil_wdata),
    .m_axil_wstrb   (m_axil_wstrb),
    .m_axil_wvalid  (m_axil_wvalid),
    .m_axil_wready  (m_axil_wready),
    .m_axil_bresp   (m_axil_bresp),
    .m_axil_bvalid  (m_axil_bvalid),
    .m_axil_bready  (m_axil_bready),
    .m_axil_araddr  (m_axil_araddr),
    .m_axil_arprot  (m_axil_arprot),
    .m_axil_arvalid (m_axil_arvalid),
    .m_axil_arready (m_axil_arready),
    .m_axil_rdata   (m_axil_rdata),
    .m_axil_rresp   (m_axil_rresp),
    .m_axil_rvalid  (m_axil_rvalid),
    .m_axil_rready  (m_axil_rready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // subordinate configuration
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;

  // monitor results
  int          n_aw, n_w, n_b, n_ar, n_r, n_ready, n_withdraw = 0, n_double = 0;
  int          aw_hold, w_hold, ar_hold;
  int          t_aw_first, t_ar_first, t_aw_hs, t_ar_hs, t_b_hs;
  logic [31:0] seen_awaddr, seen_wdata, seen_araddr;
  logic [3:0]  seen_wstrb;

  task automatic clear_counts();
    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; n_ready = 0;
    aw_hold = 0; w_hold = 0; ar_hold = 0;
    t_aw_first = -1; t_ar_first = -1; t_aw_hs = -1; t_ar_hs = -1; t_b_hs = -1;
  endtask

  // AXI-Lite subordinate and handshake monitor
  initial begin : subordinate
    int   aw_wait, w_wait, ar_wait, b_wait, r_wait;
    logic aw_got, w_got, b_armed, r_armed, prev_ready;
    aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    aw_got = 0; w_got = 0; b_armed = 0; r_armed = 0; prev_ready = 0;
    m_axil_awready = 0; m_axil_wready = 0; m_axil_arready = 0;
    m_axil_bvalid = 0; m_axil_rvalid = 0; m_axil_bresp = 0; m_axil_rresp = 0;
    m_axil_rdata = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_wait = 0; w_wait = 0; ar_wait = 0; aw_got = 0; w_got = 0;
        b_armed = 0; r_armed = 0; prev_ready = 0;
        m_axil_awready = 0; m_axil_wready = 0; m_axil_arready = 0;
        m_axil_bvalid = 0; m_axil_rvalid = 0;
      end else begin
        // valid withdrawn before its handshake
        if ((aw_wait > 0 && !m_axil_awvalid) || (w_wait > 0 && !m_axil_wvalid) ||
            (ar_wait > 0 && !m_axil_arvalid)) n_withdraw++;
        // B channel
        if (b_armed) b_wait++;
        m_axil_bvalid = b_armed && (b_wait >= b_delay);
        m_axil_bresp  = m_axil_bvalid ? bresp_cfg : 2'b00;
        if (m_axil_bvalid && m_axil_bready) begin
          n_b++; b_armed = 0; t_b_hs = cyc;
        end
        // R channel
        if (r_armed) r_wait++;
        m_axil_rvalid = r_armed && (r_wait >= r_delay);
        m_axil_rresp  = m_axil_rvalid ? rresp_cfg : 2'b00;
        m_axil_rdata  = m_axil_rvalid ? rdata_cfg : 32'h0;
        if (m_axil_rvalid && m_axil_rready) begin
          n_r++; r_armed = 0;
        end
        // AW channel
        m_axil_awready = 0;
        if (m_axil_awvalid) begin
          if (aw_wait == 0) t_aw_first = cyc;
          aw_wait++;
          m_axil_awready = (aw_wait > aw_delay);
          if (m_axil_awready) begin
            n_aw++; aw_hold = aw_wait; aw_wait = 0; aw_got = 1; t_aw_hs = cyc;
            seen_awaddr = m_axil_awaddr;
          end
        end
        // W channel
        m_axil_wready = 0;
        if (m_axil_wvalid) begin
          w_wait++;
          m_axil_wready = (w_wait > w_delay);
          if (m_axil_wready) begin
            n_w++; w_hold = w_wait; w_wait = 0; w_got = 1;
            seen_wdata = m_axil_wdata; seen_wstrb = m_axil_wstrb;
          end
        end
        if (aw_got && w_got) begin
          aw_got = 0; w_got = 0; b_armed = 1; b_wait = 0;
        end
        // AR channel
        m_axil_arready = 0;
        if (m_axil_arvalid) begin
          if (ar_wait == 0) t_ar_first = cyc;
          ar_wait++;
          m_axil_arready = (ar_wait > ar_delay);
          if (m_axil_arready) begin
            n_ar++; ar_hold = ar_wait; ar_wait = 0; r_armed = 1; r_wait = 0; t_ar_hs = cyc;
            seen_araddr = m_axil_araddr;
          end
        end
        // native completion pulse
        if (native_ready) n_ready++;
        if (native_ready && prev_ready) n_double++;
        prev_ready = native_ready;
      end
    end
  end

  // requester results
  int          t_req, t_ready;
  logic        got_ready, got_err;
  logic [31:0] got_rdata;

  // mode 0: hold request; 1: scramble addr/wdata/wstrb after sampling; 2: drop valid after sampling
  task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int mode);
    got_ready = 0;
    @(negedge clk);
    native_valid = 1; native_addr = addr; native_wdata = wdata; native_wstrb = wstrb;
    t_req = cyc;
    for (int i = 0; i < 60 && !got_ready; i++) begin
      @(negedge clk);
      if (i == 0 && mode == 1) begin
        native_addr = 32'hFFC; native_wdata = 32'h0; native_wstrb = 4'h0;
      end
      if (i == 0 && mode == 2) native_valid = 0;
      if (native_ready) begin
        got_ready = 1; got_rdata = native_rdata; got_err = native_err; t_ready = cyc;
        native_valid = 0;
      end
    end
    native_valid = 0;
    check_eq("req_completed", got_ready, 1);
  endtask

  initial begin
    int t_first_ready;
    rst_n = 0; native_valid = 0; native_addr = 0; native_wdata = 0; native_wstrb = 0;
    clear_counts();
    repeat (3) @(negedge clk);
    check_eq("rst_ctrl", {m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid,
                          m_axil_rready, native_ready, native_err}, 0);
    check_eq("rst_rdata", native_rdata, 0);
    check_eq("rst_addr", {m_axil_awaddr, m_axil_araddr}, 0);
    check_eq("rst_wdata_strb", {m_axil_wdata, m_axil_wstrb}, 0);
    check_eq("prot_tied", {m_axil_awprot, m_axil_arprot}, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // 1: minimum-latency write
    clear_counts();
    do_req(32'h100, 32'hDEADBEEF, 4'hF, 0);
    repeat (3) @(negedge clk);
    check_eq("t1_n_aw", n_aw, 1);
    check_eq("t1_n_w", n_w, 1);
    check_eq("t1_awaddr", seen_awaddr, 32'h100);
    check_eq("t1_wdata", seen_wdata, 32'hDEADBEEF);
    check_eq("t1_wstrb", seen_wstrb, 4'hF);
    check_eq("t1_aw_latency", t_aw_first - t_req, 1);
    check_eq("t1_ready_latency", t_ready - t_req, 3);
    check_eq("t1_err", got_err, 0);
    check_eq("t1_n_ready", n_ready, 1);

    // 2: awready delayed 3, wready immediate, B 2 cycles after AW, DECERR
    clear_counts();
    aw_delay = 3; b_delay = 2; bresp_cfg = 2'b11;
    do_req(32'h180, 32'h0F0F0F0F, 4'hF, 0);
    repeat (3) @(negedge clk);
    check_eq("t2_w_hold", w_hold, 1);
    check_eq("t2_aw_hold", aw_hold, 4);
    check_eq("t2_n_b", n_b, 1);
    check_eq("t2_ready_after_b", t_ready - t_b_hs, 1);
    check_eq("t2_n_ready", n_ready, 1);
    check_eq("t2_err_decerr", got_err, 1);
    aw_delay = 0; b_delay = 0; bresp_cfg = 2'b00;

    // 3: read with arready delayed 2, SLVERR, data still forwarded
    clear_counts();
    ar_delay = 2; rdata_cfg = 32'h12345678; rresp_cfg = 2'b10;
    do_req(32'h204, 32'h0, 4'h0, 0);
    repeat (3) @(negedge clk);
    check_eq("t3_n_ar", n_ar, 1);
    check_eq("t3_n_aw", n_aw, 0);
    check_eq("t3_araddr", seen_araddr, 32'h204);
    check_eq("t3_ar_hold", ar_hold, 3);
    check_eq("t3_rdata", got_rdata, 32'h12345678);
    check_eq("t3_err_slverr", got_err, 1);
    ar_delay = 0; rresp_cfg = 2'b00;

    // 4: back-to-back write then read at the same address
    clear_counts();
    do_req(32'h300, 32'hA5A51234, 4'h3, 0);
    t_first_ready = t_ready;
    check_eq("t4_rdata_held", got_rdata, 32'h12345678);
    check_eq("t4_wr_err", got_err, 0);
    rdata_cfg = 32'h0BADCAFE;
    do_req(32'h300, 32'h0, 4'h0, 0);
    repeat (3) @(negedge clk);
    check_eq("t4_wstrb", seen_wstrb, 4'h3);
    check_eq("t4_n_aw", n_aw, 1);
    check_eq("t4_n_ar", n_ar, 1);
    check_eq("t4_order", t_aw_hs < t_ar_first, 1);
    check_eq("t4_idle_gap", t_ar_first - t_first_ready, 2);
    check_eq("t4_rdata", got_rdata, 32'h0BADCAFE);
    check_eq("t4_n_ready", n_ready, 2);

    // 5: reset while waiting for B
    clear_counts();
    b_delay = 30;
    @(negedge clk);
    native_valid = 1; native_addr = 32'h340; native_wdata = 32'h55AA55AA; native_wstrb = 4'hF;
    for (int i = 0; i < 20 && !m_axil_bready; i++) @(negedge clk);
    check_eq("t5_in_wr_resp", m_axil_bready, 1);
    #2;
    rst_n = 0;
    native_valid = 0;
    #1;
    check_eq("t5_async_clear", {m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid,
                                m_axil_rready, native_ready, native_err}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    b_delay = 0;
    repeat (2) @(negedge clk);
    check_eq("t5_no_ready", n_ready, 0);
    check_eq("t5_no_b", n_b, 0);
    check_eq("t5_rdata_reset", native_rdata, 0);
    rdata_cfg = 32'hCAFEF00D;
    do_req(32'h344, 32'h0, 4'h0, 0);
    check_eq("t5_read_rdata", got_rdata, 32'hCAFEF00D);
    check_eq("t5_read_err", got_err, 0);

    // 6: request fields change after sampling
    clear_counts();
    aw_delay = 2;
    do_req(32'h400, 32'h11223344, 4'hF, 1);
    repeat (3) @(negedge clk);
    check_eq("t6_awaddr", seen_awaddr, 32'h400);
    check_eq("t6_wdata", seen_wdata, 32'h11223344);
    check_eq("t6_wstrb", seen_wstrb, 4'hF);
    check_eq("t6_n_ar", n_ar, 0);
    check_eq("t6_n_ready", n_ready, 1);
    aw_delay = 0;

    // 7: native_valid dropped mid-read still completes, DECERR
    clear_counts();
    r_delay = 3; rdata_cfg = 32'h5A5A5A5A; rresp_cfg = 2'b11;
    do_req(32'h500, 32'h0, 4'h0, 2);
    repeat (3) @(negedge clk);
    check_eq("t7_n_ready", n_ready, 1);
    check_eq("t7_rdata", got_rdata, 32'h5A5A5A5A);
    check_eq("t7_err", got_err, 1);

    check_eq("no_valid_withdrawn", n_withdraw, 0);
    check_eq("no_double_ready", n_double, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
